iir_sample_feeder: RTL and testbench

IIR_SAMPLE_FEEDER -- requirements
Module: iir_sample_feeder

---
 rtl/iir_sample_feeder.sv | 141 ++++++++++++++
 tb/tb_iir_sample_feeder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sample_feeder.sv
// Streams N samples from a ROM into an IIR filter input, then waits for the
// filter to drain (bounded by DRAIN_TIMEOUT) before pulsing done.
module iir_sample_feeder #(
   parameter int GAP           = 0,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [11:0]        num_samples,
   output logic [10:0]        mem_addr,
   output logic               mem_rd_en,
   input  logic signed [23:0] mem_rd_data,
   output logic signed [23:0] data_in,
   output logic               data_in_valid,
   input  logic               filter_done,
   output logic               busy,
   output logic               done,
   output logic               timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CAPTURE,
      S_GAP_WAIT,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [11:0]        r_cnt;
   logic [11:0]        r_n;
   logic [15:0]        r_wait;
   logic signed [23:0] r_data;
   logic               r_valid;
   logic               r_timeout;

   logic               w_accept;
   logic               w_capture;
   logic               w_wait_clr;
   logic               w_set_to;
   logic               w_last;
   logic [11:0]        w_n_clamp;

   assign w_n_clamp = (num_samples > 12'd2048) ? 12'd2048 : num_samples;
   assign w_last    = ((r_cnt + 12'd1) == r_n);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_capture  = 1'b0;
      w_wait_clr = 1'b0;
      w_set_to   = 1'b0;
      mem_rd_en  = 1'b0;
      mem_addr   = 11'd0;
      busy       = (r_state != S_IDLE);
      done       = (r_state == S_FINISH);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = (num_samples == 12'd0) ? S_FINISH : S_READ;
            end
         end
         S_READ: begin
            mem_rd_en = 1'b1;
            mem_addr  = r_cnt[10:0];
            w_next    = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_capture = 1'b1;
            if (w_last) begin
               w_next     = S_DRAIN;
               w_wait_clr = 1'b1;
            end else if (GAP > 0) begin
               w_next     = S_GAP_WAIT;
               w_wait_clr = 1'b1;
            end else begin
               w_next     = S_READ;
            end
         end
         S_GAP_WAIT: begin
            if (r_wait == 16'(GAP - 1)) w_next = S_READ;
         end
         S_DRAIN: begin
            if (filter_done) begin
               w_next = S_FINISH;
            end else if (r_wait == 16'(DRAIN_TIMEOUT - 1)) begin
               w_next   = S_FINISH;
               w_set_to = 1'b1;
            end
         end
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      // Abort beats filter_done, timeout and a pending capture alike.
      if (abort && (r_state != S_IDLE)) begin
         w_next     = S_IDLE;
         w_capture  = 1'b0;
         w_wait_clr = 1'b0;
         w_set_to   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= 12'd0;
         r_n       <= 12'd0;
         r_wait    <= 16'd0;
         r_data    <= 24'sd0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_valid <= w_capture;
         r_wait  <= w_wait_clr ? 16'd0 : (r_wait + 16'd1);
         if (w_capture) begin
            r_data <= mem_rd_data;
            r_cnt  <= r_cnt + 12'd1;
         end
         if (w_accept) begin
            r_n       <= w_n_clamp;
            r_cnt     <= 12'd0;
            r_timeout <= 1'b0;
         end
         if (w_set_to) r_timeout <= 1'b1;
      end
   end

   assign data_in       = r_data;
   assign data_in_valid = r_valid;
   assign timeout       = r_timeout;

endmodule

// File: tb/tb_iir_sample_feeder.sv
// Bench for iir_sample_feeder: ROM model returns addr+1, a scoreboard queue holds
// the expected sample stream; each scenario task checks its own results.
module tb_iir_sample_feeder;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic               fd = 1'b0;
   logic [11:0]        num = 12'd0;
   logic [10:0]        mem_addr;
   logic               mem_rd_en;
   logic signed [23:0] mem_rd_data = 24'sd0;
   logic signed [23:0] data_in;
   logic               data_in_valid, busy, done, timeout;

   logic               g_start = 1'b0;
   logic               g_abort = 1'b0;
   logic               g_fd = 1'b0;
   logic [10:0]        g_addr;
   logic               g_rd_en;
   logic signed [23:0] g_rd_data = 24'sd0;
   logic signed [23:0] g_data;
   logic               g_valid, g_busy, g_done, g_to;

   always #5 clk = ~clk;

   iir_sample_feeder u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
      .data_in(data_in), .data_in_valid(data_in_valid), .filter_done(fd),
      .busy(busy), .done(done), .timeout(timeout));

   iir_sample_feeder #(.GAP(3)) u_gap (
      .clk(clk), .rst(rst), .start(g_start), .abort(g_abort), .num_samples(num),
      .mem_addr(g_addr), .mem_rd_en(g_rd_en), .mem_rd_data(g_rd_data),
      .data_in(g_data), .data_in_valid(g_valid), .filter_done(g_fd),
      .busy(g_busy), .done(g_done), .timeout(g_to));

   // ROM model: ROM[i] = i+1, one cycle read latency
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= {13'd0, mem_addr} + 24'd1;
      if (g_rd_en)   g_rd_data   <= {13'd0, g_addr} + 24'd1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_err = 0;
   int vld_cnt = 0, rd_cnt = 0, t0 = 0, done_cyc = 0;
   logic [11:0] exp_addr = 12'd0;
   logic [10:0] last_addr = 11'd0;
   logic signed [23:0] exp_q[$];
   int vcyc_q[$];
   logic [10:0] g_addr_q[$];
   logic signed [23:0] g_dat_q[$];
   int g_vcyc_q[$];

   always @(negedge clk) begin
      if (mem_rd_en) begin
         n_cmp++;
         if (mem_addr !== exp_addr[10:0]) begin
            n_err++;
            $display("FAIL rd_addr: got %0h want %0h", mem_addr, exp_addr[10:0]);
         end
         exp_addr  = exp_addr + 12'd1;
         last_addr = mem_addr;
         rd_cnt++;
      end
      if (data_in_valid) begin
         vld_cnt++;
         vcyc_q.push_back(cyc);
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid: got data %0d want no valid", data_in);
         end else begin
            logic signed [23:0] e;
            e = exp_q.pop_front();
            if (data_in !== e) begin
               n_err++;
               $display("FAIL data_in: got %0d want %0d", data_in, e);
            end
         end
      end
      if (g_rd_en) g_addr_q.push_back(g_addr);
      if (g_valid) begin
         g_vcyc_q.push_back(cyc);
         g_dat_q.push_back(g_data);
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   task automatic wait_vld(input int cnt, input int budget);
      for (int i = 0; i < budget && vld_cnt < cnt; i++) begin @(negedge clk); #1; end
   endtask

   task automatic start_run(input int n);
      @(negedge clk);
      num = 12'(n);
      exp_addr = 12'd0; vld_cnt = 0; rd_cnt = 0;
      vcyc_q.delete(); exp_q.delete();
      for (int i = 0; i < ((n > 2048) ? 2048 : n); i++) exp_q.push_back(24'(i + 1));
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      t0 = cyc;
   endtask

   task automatic drain_done(input bit give_fd, input int budget, output bit ok);
      ok = 1'b0;
      if (give_fd) begin @(posedge clk); #1 fd = 1'b1; @(posedge clk); #1 fd = 1'b0; end
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; done_cyc = cyc; end
      end
   endtask

   task automatic test_reset;
      #12;
      n_cmp++;
      if ({mem_addr, mem_rd_en, data_in, data_in_valid, busy, done, timeout} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%b done=%b vld=%b addr=%0h want all 0",
                  busy, done, data_in_valid, mem_addr);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic;
      start_run(4);
      wait_vld(4, 12);
      n_cmp++;
      if (vld_cnt != 4) begin n_err++; $display("FAIL basic_count: got %0d want 4", vld_cnt); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (vcyc_q.size() <= k || vcyc_q[k] - t0 != 2 + 2 * k) begin
            n_err++;
            $display("FAIL basic_timing[%0d]: got %0d want %0d", k,
                     (vcyc_q.size() > k) ? vcyc_q[k] - t0 : -1, 2 + 2 * k);
         end
      end
      wait_cyc(t0 + 11);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         n_err++; $display("FAIL basic_drain: got done=%b busy=%b want 0 1", done, busy);
      end
      fd = 1'b1;
      wait_cyc(t0 + 12);
      fd = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         n_err++; $display("FAIL basic_done: got done=%b busy=%b want 1 1", done, busy);
      end
      @(negedge clk);
      n_cmp++;
      if ({done, busy, timeout} !== 3'b000) begin
         n_err++; $display("FAIL basic_idle: got done/busy/to=%b want 000", {done, busy, timeout});
      end
   endtask

   task automatic test_gap;
      bit ok;
      @(negedge clk);
      num = 12'd2;
      g_addr_q.delete(); g_dat_q.delete(); g_vcyc_q.delete();
      g_start = 1'b1;
      @(posedge clk); #1 g_start = 1'b0;
      t0 = cyc;
      for (int i = 0; i < 20 && g_vcyc_q.size() < 2; i++) begin @(negedge clk); #1; end
      n_cmp++;
      if (g_vcyc_q.size() != 2 || g_vcyc_q[0] - t0 != 2 || g_vcyc_q[1] - g_vcyc_q[0] != 5) begin
         n_err++;
         $display("FAIL gap_timing: got n=%0d first=%0d spacing=%0d want 2 2 5", g_vcyc_q.size(),
                  (g_vcyc_q.size() > 0) ? g_vcyc_q[0] - t0 : -1,
                  (g_vcyc_q.size() > 1) ? g_vcyc_q[1] - g_vcyc_q[0] : -1);
      end
      n_cmp++;
      if (g_addr_q.size() != 2 || g_addr_q[0] !== 11'd0 || g_addr_q[1] !== 11'd1) begin
         n_err++; $display("FAIL gap_addr: got %0d reads want addrs 0,1", g_addr_q.size());
      end
      n_cmp++;
      if (g_dat_q.size() != 2 || g_dat_q[0] !== 24'sd1 || g_dat_q[1] !== 24'sd2) begin
         n_err++; $display("FAIL gap_data: got %0d samples want 1,2", g_dat_q.size());
      end
      g_fd = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 5 && !ok; i++) begin @(negedge clk); if (g_done) ok = 1'b1; end
      g_fd = 1'b0;
      n_cmp++;
      if (!ok || g_to !== 1'b0) begin
         n_err++; $display("FAIL gap_done: got done=%b to=%b want 1 0", ok, g_to);
      end
   endtask

   task automatic test_timeout;
      bit ok;
      start_run(1);
      drain_done(1'b0, 100, ok);
      n_cmp++;
      if (!ok || done_cyc - t0 != 66) begin
         n_err++; $display("FAIL timeout_latency: got done=%b at %0d want 1 at 66", ok, done_cyc - t0);
      end
      n_cmp++;
      if (timeout !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b want 1", timeout); end
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if (timeout !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL timeout_sticky: got to=%b busy=%b want 1 0", timeout, busy);
      end
   endtask

   task automatic test_zero;
      bit ok;
      start_run(0);
      drain_done(1'b0, 3, ok);
      n_cmp++;
      if (!ok || done_cyc - t0 > 2) begin
         n_err++; $display("FAIL zero_done: got done=%b at %0d want within 2", ok, done_cyc - t0);
      end
      n_cmp++;
      if (rd_cnt != 0 || vld_cnt != 0 || timeout !== 1'b0) begin
         n_err++; $display("FAIL zero_activity: got rd=%0d vld=%0d to=%b want 0 0 0", rd_cnt, vld_cnt, timeout);
      end
   endtask

   task automatic test_clamp;
      bit ok;
      start_run(4095);
      wait_vld(2048, 4300);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (vld_cnt != 2048 || rd_cnt != 2048) begin
         n_err++; $display("FAIL clamp_count: got vld=%0d rd=%0d want 2048", vld_cnt, rd_cnt);
      end
      n_cmp++;
      if (last_addr !== 11'h7FF || exp_q.size() != 0) begin
         n_err++; $display("FAIL clamp_last_addr: got %0h left=%0d want 7ff 0", last_addr, exp_q.size());
      end
      drain_done(1'b1, 5, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL clamp_done: got 0 want 1"); end
   endtask

   task automatic test_abort;
      bit ok, saw_done;
      start_run(8);
      wait_cyc(t0 + 4);
      abort = 1'b1;
      wait_cyc(t0 + 5);
      abort = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || vld_cnt != 2) begin
         n_err++; $display("FAIL abort_stop: got busy=%b vld=%0d want 0 2", busy, vld_cnt);
      end
      saw_done = 1'b0;
      repeat (10) begin @(negedge clk); if (done) saw_done = 1'b1; end
      n_cmp++;
      if (saw_done || vld_cnt != 2) begin
         n_err++; $display("FAIL abort_quiet: got done=%b vld=%0d want 0 2", saw_done, vld_cnt);
      end
      start_run(3);
      wait_vld(3, 12);
      drain_done(1'b1, 5, ok);
      n_cmp++;
      if (!ok || vld_cnt != 3 || exp_q.size() != 0) begin
         n_err++; $display("FAIL abort_rerun: got done=%b vld=%0d want 1 3", ok, vld_cnt);
      end
   endtask

   task automatic test_reset_mid;
      start_run(8);
      wait_cyc(t0 + 3);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({mem_addr, mem_rd_en, data_in, data_in_valid, busy, done, timeout} !== '0) begin
         n_err++; $display("FAIL reset_mid: got busy=%b data=%0d want all 0", busy, data_in);
      end
      @(negedge clk); rst = 1'b0;
      repeat (8) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || vld_cnt != 1) begin
         n_err++; $display("FAIL reset_no_resume: got busy=%b vld=%0d want 0 1", busy, vld_cnt);
      end
   endtask

   task automatic test_restart;
      bit ok;
      start_run(4);
      wait_cyc(t0 + 3);
      num = 12'd100; start = 1'b1;
      wait_cyc(t0 + 4);
      start = 1'b0; num = 12'd4;
      wait_vld(4, 15);
      drain_done(1'b1, 5, ok);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (!ok || vld_cnt != 4 || rd_cnt != 4 || busy !== 1'b0) begin
         n_err++; $display("FAIL restart_ignored: got done=%b vld=%0d rd=%0d want 1 4 4", ok, vld_cnt, rd_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_gap;
      test_timeout;
      test_zero;
      test_clamp;
      test_abort;
      test_reset_mid;
      test_restart;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
